// File: rtl/stepper_full_step_seq.sv
`default_nettype none
// ============================================================================
// Module   : stepper_full_step_seq
// Brief    : Full-step (two-phase-on) 4-wire stepper sequencer with position.
// Revision : 1.0 - initial release
// ============================================================================

module stepper_full_step_seq #(
  parameter int CNT_W = 16,
  parameter int POS_W = 16,
  parameter bit HOLD  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_clk,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] num_steps,
  input  logic             stop,
  output logic [3:0]       coils,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [1:0]       r_phase;
  logic             r_dir;
  logic [CNT_W-1:0] r_remaining;

  logic             w_tick;
  logic [1:0]       w_next_phase;
  logic [POS_W-1:0] w_next_pos;

  function automatic logic [3:0] phase_coils(input logic [1:0] p);
    case (p)
      2'd0:    phase_coils = 4'b1100;
      2'd1:    phase_coils = 4'b0110;
      2'd2:    phase_coils = 4'b0011;
      default: phase_coils = 4'b1001;
    endcase
  endfunction

  // step_clk is asynchronous: two flops to resolve metastability, a third for edge detect
  assign w_tick       = r_s2 & ~r_s3;
  assign w_next_phase = r_dir ? (r_phase + 2'd1) : (r_phase - 2'd1);
  assign w_next_pos   = r_dir ? (position + POS_W'(1)) : (position - POS_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_phase     <= 2'd0;
      r_dir       <= 1'b0;
      r_remaining <= '0;
      position    <= '0;
      coils       <= 4'b0000;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_s1 <= step_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dir       <= dir;
            r_remaining <= num_steps;
            if (num_steps == '0) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              busy    <= 1'b1;
              coils   <= phase_coils(r_phase);
            end
          end
        end

        ST_RUN: begin
          if (stop) begin
            // abort beats a coincident tick; leftover steps are dropped
            r_state     <= ST_DONE;
            r_remaining <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            coils       <= HOLD ? phase_coils(r_phase) : 4'b0000;
          end else if (w_tick) begin
            r_phase     <= w_next_phase;
            r_remaining <= r_remaining - CNT_W'(1);
            position    <= w_next_pos;
            if (r_remaining == CNT_W'(1)) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              coils   <= HOLD ? phase_coils(w_next_phase) : 4'b0000;
            end else begin
              coils   <= phase_coils(w_next_phase);
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stepper_full_step_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_stepper_full_step_seq
// Brief    : Self-checking bench; HOLD=1 and HOLD=0 instances share stimulus.
// Revision : 1.0 - initial release
// ============================================================================

module tb_stepper_full_step_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_clk;
  logic        start;
  logic        dir;
  logic [15:0] num_steps;
  logic        stop;

  logic [3:0]  coils_h, coils_z;
  logic        busy_h, busy_z, done_h, done_z;
  logic [15:0] pos_h, pos_z;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: phase as integer mod 4, position as plain 16-bit count
  logic [3:0]  tbl [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
  int          m_phase;
  int          m_rem;
  logic [15:0] m_pos;
  logic [3:0]  m_last;
  logic        m_run;
  logic        m_dir;

  always #5 clk = ~clk;

  stepper_full_step_seq #(.CNT_W(16), .POS_W(16), .HOLD(1'b1)) u_hold (
    .clk(clk), .rst(rst), .step_clk(step_clk), .start(start), .dir(dir),
    .num_steps(num_steps), .stop(stop), .coils(coils_h), .busy(busy_h),
    .done(done_h), .position(pos_h)
  );

  stepper_full_step_seq #(.CNT_W(16), .POS_W(16), .HOLD(1'b0)) u_nohold (
    .clk(clk), .rst(rst), .step_clk(step_clk), .start(start), .dir(dir),
    .num_steps(num_steps), .stop(stop), .coils(coils_z), .busy(busy_z),
    .done(done_z), .position(pos_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_done);
    chk({tag, "/coils_h"}, 32'(coils_h), 32'(m_last));
    chk({tag, "/coils_z"}, 32'(coils_z), 32'(m_run ? tbl[m_phase] : 4'b0000));
    chk({tag, "/busy_h"},  32'(busy_h),  32'(m_run));
    chk({tag, "/busy_z"},  32'(busy_z),  32'(m_run));
    chk({tag, "/done_h"},  32'(done_h),  32'(exp_done));
    chk({tag, "/done_z"},  32'(done_z),  32'(exp_done));
    chk({tag, "/pos_h"},   32'(pos_h),   32'(m_pos));
    chk({tag, "/pos_z"},   32'(pos_z),   32'(m_pos));
  endtask

  task automatic model_reset();
    m_phase = 0; m_rem = 0; m_pos = 16'h0000; m_last = 4'b0000; m_run = 1'b0; m_dir = 1'b0;
  endtask

  // rst low for n edges; every edge must show reset values and no done
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0; step_clk = 1'b0; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      model_reset();
      check_all("reset", 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start_cmd(input logic d, input int n);
    logic zero;
    zero = (n == 0);
    @(negedge clk);
    start = 1'b1; dir = d; num_steps = 16'(n);
    @(posedge clk); #1;
    if (!zero) begin
      m_run = 1'b1; m_dir = d; m_rem = n; m_last = tbl[m_phase];
    end
    check_all("start", zero);
    @(negedge clk);
    start = 1'b0; dir = $urandom_range(0, 1);
    @(posedge clk); #1;
    check_all("start+1", 1'b0);
  endtask

  // one step_clk pulse; do_stop raises stop in the cycle the tick is seen
  task automatic step(input logic do_stop, input logic noise);
    logic exp_done;
    exp_done = 1'b0;
    @(negedge clk);
    step_clk = 1'b1;
    if (noise && m_run) begin
      start = 1'b1; num_steps = 16'($urandom_range(0, 9));
    end
    dir = $urandom_range(0, 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dir = $urandom_range(0, 1);
    @(posedge clk); #1;
    check_all("pre_tick", 1'b0);
    @(negedge clk);
    stop = do_stop;
    @(posedge clk); #1;
    if (m_run) begin
      if (do_stop) begin
        m_run = 1'b0; exp_done = 1'b1;
      end else begin
        m_phase = (m_phase + (m_dir ? 1 : 3)) % 4;
        m_pos   = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
        m_last  = tbl[m_phase];
        m_rem   = m_rem - 1;
        if (m_rem == 0) begin
          m_run = 1'b0; exp_done = 1'b1;
        end
      end
    end
    check_all("tick", exp_done);
    @(negedge clk);
    stop = 1'b0;
    @(posedge clk); #1;
    check_all("post_tick", 1'b0);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(negedge clk);
    step_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("fall", 1'b0);
  endtask

  initial begin
    rst = 1'b0; step_clk = 1'b0; start = 1'b0; dir = 1'b0; num_steps = '0; stop = 1'b0;
    model_reset();

    do_reset(3);
    @(posedge clk); #1;
    check_all("idle", 1'b0);
    repeat (5) step(1'b0, 1'b0);

    start_cmd(1'b1, 6);
    repeat (6) step(1'b0, 1'b0);

    start_cmd(1'b0, 3);
    repeat (3) step(1'b0, 1'b0);

    start_cmd(1'b1, 0);

    start_cmd(1'b1, 4);
    repeat (4) step(1'b0, 1'b1);

    start_cmd(1'b1, 10);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    start_cmd(1'b0, 5);
    step(1'b0, 1'b0);
    do_reset(3);

    start_cmd(1'b0, 1);
    step(1'b0, 1'b0);
    chk("wrap_pos", 32'(pos_h), 32'h0000_FFFF);
    chk("wrap_coils_z", 32'(coils_z), 32'h0);

    for (int r = 0; r < 8; r++) begin
      start_cmd($urandom_range(0, 1), $urandom_range(0, 5));
      for (int k = 0; k < 6; k++)
        step($urandom_range(0, 7) == 0, $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
